// File: rtl/cfg_loader_if.sv
// cfg_loader_if: bitstream input handshake, fabric programming outputs and session status.
interface cfg_loader_if #(
  parameter int CHAINS = 7
);
  logic              start;
  logic [31:0]       in_data;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       prog_i;
  logic [CHAINS-1:0] prog_shft;
  logic              data_en;
  logic              busy;
  logic              err;
  logic [CHAINS-1:0] loaded;
  modport master (
    output start, in_data, in_valid,
    input  in_ready, prog_i, prog_shft, data_en, busy, err, loaded
  );
  modport slave (
    input  start, in_data, in_valid,
    output in_ready, prog_i, prog_shft, data_en, busy, err, loaded
  );
endinterface

// File: rtl/cfg_loader.sv
// cfg_loader: parses a header/data/trailer bitstream and shifts words into one-hot selected fabric chains.
module cfg_loader #(
  parameter int CHAINS = 7,
  parameter int WORDS  = 8
) (
  input logic        clk,
  input logic        res,
  cfg_loader_if.slave bus
);
  localparam int SW = CHAINS > 1 ? $clog2(CHAINS) : 1;
  localparam int CW = WORDS > 1 ? $clog2(WORDS) : 1;
  localparam logic [31:0] TRAILER = 32'hE000_0000;
  typedef enum logic [2:0] {IDLE, HDR, LOAD, DONE, ERR} state_t;
  state_t            state_q, state_d;
  logic [SW-1:0]     sel_q, sel_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CHAINS-1:0] loaded_q, loaded_d, shft_q, shft_d;
  logic [31:0]       prog_q, prog_d;
  logic              active, hdr_ok;
  assign active        = state_q == HDR || state_q == LOAD;
  assign hdr_ok        = bus.in_data[31:24] == 8'hC5 && 32'(bus.in_data[7:0]) < CHAINS;
  assign bus.in_ready  = active;
  assign bus.busy      = active;
  assign bus.data_en   = state_q == DONE;
  assign bus.err       = state_q == ERR;
  assign bus.prog_i    = prog_q;
  assign bus.prog_shft = shft_q;
  assign bus.loaded    = loaded_q;
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    loaded_d = loaded_q;
    prog_d   = prog_q;
    shft_d   = '0;
    unique case (state_q)
      IDLE, DONE, ERR: if (bus.start) begin
        state_d  = HDR;
        loaded_d = '0;
      end
      HDR: if (bus.in_valid) begin
        state_d = bus.in_data == TRAILER ? (&loaded_q ? DONE : ERR) : hdr_ok ? LOAD : ERR;
        sel_d   = hdr_ok ? SW'(bus.in_data[7:0]) : sel_q;
        cnt_d   = '0;
      end
      LOAD: if (bus.in_valid) begin
        prog_d = bus.in_data;
        shft_d = CHAINS'(1) << sel_q;
        cnt_d  = cnt_q + CW'(1);
        // last word of the chain: mark it loaded and expect the next header
        if (cnt_q == CW'(WORDS - 1)) begin
          loaded_d[sel_q] = 1'b1;
          state_d         = HDR;
          cnt_d           = '0;
        end
      end
      default: ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (res) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      cnt_q    <= '0;
      loaded_q <= '0;
      prog_q   <= '0;
      shft_q   <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      loaded_q <= loaded_d;
      prog_q   <= prog_d;
      shft_q   <= shft_d;
    end
  end
endmodule
